instruction_fetch_unit: RTL and testbench

Fetch stage that drives the address input of `ProgramMemory` and registers the 16-bit instruction it returns. It holds the program counter (PC) and an instruction register (IR) with a valid/ready handshake to the downstream decoder/controller. It also supports jumps with IR flush, halt, and an issued-instruction counter. The ROM is combinational, so a fetch completes in the same cycle its address is presented.

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_program_counter.sv | 44 ++++
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_pkg
// Brief    : Shared state encodings and default widths for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 8;
    localparam int DEFAULT_INSTR_WIDTH = 16;
    localparam int COUNT_WIDTH         = 16;

    // Code 2'b11 is unused; the FSM treats it as a return to idle.
    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'b00,
        FETCH_RUN    = 2'b01,
        FETCH_HALTED = 2'b10
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_program_counter.sv
`default_nettype none
// ============================================================================
// Module   : program_counter
// Brief    : Program counter with load (jump), increment and natural wrap.
// Revision : 1.0 - initial release
// ============================================================================
module program_counter #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  incr_en,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Next PC: a load takes precedence over an increment; the add wraps.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_value;
        end else if (incr_en) begin
            pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // PC register with asynchronous reset to the configured start address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= ADDR_WIDTH'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Fetch stage: PC, instruction register with valid/ready handshake,
//            jump with IR flush, halt, and an issued-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int          INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic [ADDR_WIDTH-1:0]  pc_address,
    input  logic [INSTR_WIDTH-1:0] rom_instruction,
    output logic [INSTR_WIDTH-1:0] ir_out,
    output logic [ADDR_WIDTH-1:0]  ir_pc,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    input  logic                   jump_en,
    input  logic [ADDR_WIDTH-1:0]  jump_target,
    input  logic                   halt,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] issued_count
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    fetch_state_e           state_q;
    fetch_state_e           state_d;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [INSTR_WIDTH-1:0] ir_d;
    logic [ADDR_WIDTH-1:0]  ir_pc_q;
    logic [ADDR_WIDTH-1:0]  ir_pc_d;
    logic                   ir_valid_q;
    logic                   ir_valid_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    logic [ADDR_WIDTH-1:0]  pc;
    logic                   jump_take;
    logic                   fetch;
    logic                   handshake;

    // Jumps are honoured only once running; a fetch needs a free or draining IR.
    always_comb begin
        jump_take = jump_en && ((state_q == FETCH_RUN) || (state_q == FETCH_HALTED));
        handshake = ir_valid_q && ir_ready;
        fetch     = (state_q == FETCH_RUN) && !jump_en && (!ir_valid_q || ir_ready);
    end

    // Next-state logic: jump beats halt, and only a jump leaves HALTED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE:   state_d = FETCH_RUN;
            FETCH_RUN: begin
                if (jump_en) begin
                    state_d = FETCH_RUN;
                end else if (halt) begin
                    state_d = FETCH_HALTED;
                end
            end
            FETCH_HALTED: begin
                if (jump_en) begin
                    state_d = FETCH_RUN;
                end
            end
            default:      state_d = FETCH_IDLE;
        endcase
    end

    // IR, valid flag and issue counter updates.
    always_comb begin
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        count_d    = count_q;

        if (fetch) begin
            ir_d       = rom_instruction;
            ir_pc_d    = pc;
            ir_valid_d = 1'b1;
        end

        // A jump flushes the IR; a consumed IR with no refill goes empty.
        if (jump_take) begin
            ir_valid_d = 1'b0;
        end else if (handshake && !fetch) begin
            ir_valid_d = 1'b0;
        end

        if (handshake && (count_q != COUNT_MAX)) begin
            count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State and IR registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH_IDLE;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            count_q    <= count_d;
        end
    end

    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_program_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_en    (jump_take),
        .load_value (jump_target),
        .incr_en    (fetch),
        .pc         (pc)
    );

    assign pc_address   = pc;
    assign ir_out       = ir_q;
    assign ir_pc        = ir_pc_q;
    assign ir_valid     = ir_valid_q;
    assign halted       = (state_q == FETCH_HALTED);
    assign issued_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed vector bench for instruction_fetch_unit with a
//            combinational ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [7:0]  pc_address;
    logic [15:0] rom_instruction;
    logic [15:0] ir_out;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump_en;
    logic [7:0]  jump_target;
    logic        halt;
    logic        halted;
    logic [15:0] issued_count;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        ready;
        logic        jmp;
        logic [7:0]  tgt;
        logic        hlt;
        logic        exp_valid;
        logic [15:0] exp_ir;
        logic [7:0]  exp_irpc;
        logic [7:0]  exp_pc;
        logic        exp_halted;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    instruction_fetch_unit #(
        .ADDR_WIDTH  (8),
        .INSTR_WIDTH (16),
        .RESET_PC    (0)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pc_address      (pc_address),
        .rom_instruction (rom_instruction),
        .ir_out          (ir_out),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .jump_en         (jump_en),
        .jump_target     (jump_target),
        .halt            (halt),
        .halted          (halted),
        .issued_count    (issued_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program contents: 0x1111..0x4444 at 0..3, otherwise 0xC0 followed by the address.
    function automatic logic [15:0] rom_val(input logic [7:0] a);
        case (a)
            8'h00:   rom_val = 16'h1111;
            8'h01:   rom_val = 16'h2222;
            8'h02:   rom_val = 16'h3333;
            8'h03:   rom_val = 16'h4444;
            default: rom_val = {8'hC0, a};
        endcase
    endfunction

    always_comb rom_instruction = rom_val(pc_address);

    function automatic vec_t mk(input logic r, input logic j, input logic [7:0] t,
                                input logic h, input logic ev, input logic [15:0] eir,
                                input logic [7:0] eirpc, input logic [7:0] epc,
                                input logic eh, input logic [15:0] ec);
        vec_t v;
        v.ready = r; v.jmp = j; v.tgt = t; v.hlt = h;
        v.exp_valid = ev; v.exp_ir = eir; v.exp_irpc = eirpc; v.exp_pc = epc;
        v.exp_halted = eh; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic ev, input logic [15:0] eir,
                         input logic [7:0] eirpc, input logic [7:0] epc,
                         input logic eh, input logic [15:0] ec);
        tests_run++;
        if (ir_valid !== ev || ir_out !== eir || ir_pc !== eirpc ||
            pc_address !== epc || halted !== eh || issued_count !== ec) begin
            tests_failed++;
            $display("FAIL %s: got valid=%b ir=%h irpc=%h pc=%h halted=%b cnt=%0d, expected valid=%b ir=%h irpc=%h pc=%h halted=%b cnt=%0d",
                     name, ir_valid, ir_out, ir_pc, pc_address, halted, issued_count,
                     ev, eir, eirpc, epc, eh, ec);
        end
    endtask

    task automatic drive(input logic r, input logic j, input logic [7:0] t, input logic h);
        ir_ready    = r;
        jump_en     = j;
        jump_target = t;
        halt        = h;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //            rdy jmp tgt    hlt  vld ir        irpc   pc     hlt  cnt
        vecs[0]  = mk(1, 0, 8'h00, 0,  0, 16'h0000, 8'h00, 8'h00, 0, 16'd0);  // IDLE->RUN
        vecs[1]  = mk(1, 0, 8'h00, 0,  1, 16'h1111, 8'h00, 8'h01, 0, 16'd0);
        vecs[2]  = mk(1, 0, 8'h00, 0,  1, 16'h2222, 8'h01, 8'h02, 0, 16'd1);
        vecs[3]  = mk(1, 0, 8'h00, 0,  1, 16'h3333, 8'h02, 8'h03, 0, 16'd2);
        vecs[4]  = mk(1, 0, 8'h00, 0,  1, 16'h4444, 8'h03, 8'h04, 0, 16'd3);
        vecs[5]  = mk(0, 0, 8'h00, 0,  1, 16'h4444, 8'h03, 8'h04, 0, 16'd3);  // backpressure
        vecs[6]  = mk(0, 0, 8'h00, 0,  1, 16'h4444, 8'h03, 8'h04, 0, 16'd3);
        vecs[7]  = mk(0, 0, 8'h00, 0,  1, 16'h4444, 8'h03, 8'h04, 0, 16'd3);
        vecs[8]  = mk(1, 0, 8'h00, 0,  1, 16'hC004, 8'h04, 8'h05, 0, 16'd4);
        vecs[9]  = mk(1, 1, 8'h80, 0,  0, 16'hC004, 8'h04, 8'h80, 0, 16'd5);  // jump bubble
        vecs[10] = mk(1, 0, 8'h00, 0,  1, 16'hC080, 8'h80, 8'h81, 0, 16'd5);
        vecs[11] = mk(1, 0, 8'h00, 0,  1, 16'hC081, 8'h81, 8'h82, 0, 16'd6);
        vecs[12] = mk(1, 1, 8'hFE, 0,  0, 16'hC081, 8'h81, 8'hFE, 0, 16'd7);  // jump to wrap
        vecs[13] = mk(1, 0, 8'h00, 0,  1, 16'hC0FE, 8'hFE, 8'hFF, 0, 16'd7);
        vecs[14] = mk(1, 0, 8'h00, 0,  1, 16'hC0FF, 8'hFF, 8'h00, 0, 16'd8);
        vecs[15] = mk(1, 0, 8'h00, 0,  1, 16'h1111, 8'h00, 8'h01, 0, 16'd9);
        vecs[16] = mk(0, 0, 8'h00, 1,  1, 16'h1111, 8'h00, 8'h01, 1, 16'd9);  // halt while stalled
        vecs[17] = mk(0, 0, 8'h00, 0,  1, 16'h1111, 8'h00, 8'h01, 1, 16'd9);
        vecs[18] = mk(1, 0, 8'h00, 0,  0, 16'h1111, 8'h00, 8'h01, 1, 16'd10); // drain
        vecs[19] = mk(1, 0, 8'h00, 0,  0, 16'h1111, 8'h00, 8'h01, 1, 16'd10);
        vecs[20] = mk(1, 1, 8'h10, 0,  0, 16'h1111, 8'h00, 8'h10, 0, 16'd10); // resume via jump
        vecs[21] = mk(1, 0, 8'h00, 0,  1, 16'hC010, 8'h10, 8'h11, 0, 16'd10);
        vecs[22] = mk(1, 1, 8'h40, 1,  0, 16'hC010, 8'h10, 8'h40, 0, 16'd11); // jump beats halt
        vecs[23] = mk(1, 0, 8'h00, 0,  1, 16'hC040, 8'h40, 8'h41, 0, 16'd11);
        vecs[24] = mk(1, 0, 8'h00, 0,  1, 16'hC041, 8'h41, 8'h42, 0, 16'd12);

        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 16'd0);

        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ready, vecs[i].jmp, vecs[i].tgt, vecs[i].hlt);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ir,
                  vecs[i].exp_irpc, vecs[i].exp_pc, vecs[i].exp_halted, vecs[i].exp_cnt);
            @(negedge clock);
        end

        // Asynchronous reset between edges clears everything without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Jump and halt in IDLE are ignored; the first edge only leaves IDLE.
        drive(1'b1, 1'b1, 8'h33, 1'b1);
        @(posedge clock);
        #1;
        check("idle_ignores_jump", 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 16'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clock);
        #1;
        check("first_fetch_after_reset", 1'b1, 16'h1111, 8'h00, 8'h01, 1'b0, 16'd0);
        @(negedge clock);

        // Halt with ready high: the fetch on the halt edge still happens.
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        @(posedge clock);
        #1;
        check("halt_edge_fetch", 1'b1, 16'h2222, 8'h01, 8'h02, 1'b1, 16'd1);
        @(negedge clock);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clock);
        #1;
        check("halted_drain", 1'b0, 16'h2222, 8'h01, 8'h02, 1'b1, 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
